// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter
// Round-robin front end for one shared, non-stalling, pipelined multiplier.
// Requesters hand over operand pairs with valid/ready. At most one pair per
// cycle goes to the multiplier. A tag pipeline as deep as the multiplier
// latency routes each product back to the requester that issued it.
//
// Ports:
//   CLK         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   per-requester operand pair present
//   req_ready   one-hot grant (combinational from req_valid)
//   req_a/req_b packed operands, requester i at [i*W +: W]
//   mul_a/mul_b operands to the multiplier (zero when nothing is granted)
//   mul_c       product returned by the multiplier
//   resp_valid  one-hot, one cycle per completed operation
//   resp_data   product for the flagged requester (holds otherwise)
//   inflight    number of operations currently in the tag pipeline
module mul_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int MUL_LAT = 2
) (
    input  logic                         CLK,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*W-1:0]            req_a,
    input  logic [NREQ*W-1:0]            req_b,
    output logic [W-1:0]                 mul_a,
    output logic [W-1:0]                 mul_b,
    input  logic [W-1:0]                 mul_c,
    output logic [NREQ-1:0]              resp_valid,
    output logic [W-1:0]                 resp_data,
    output logic [$clog2(MUL_LAT+1)-1:0] inflight
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MUL_LAT + 1);

    logic [IW-1:0]      ptr_r;
    logic [IW-1:0]      grant_idx_s;
    logic               grant_any_s;
    logic [NREQ-1:0]    grant_s;
    logic [MUL_LAT-1:0] tag_valid_r;
    logic [IW-1:0]      tag_idx_r [MUL_LAT];
    logic [NREQ-1:0]    resp_valid_r;
    logic [W-1:0]       resp_data_r;
    logic [CW-1:0]      inflight_r;
    logic [CW-1:0]      inflight_next_s;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Round-robin search: first valid requester after the last granted one.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(ptr_r) + k) % NREQ;
            cand_idx = IW'(cand);
            if (!grant_any_s && req_valid[cand_idx]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand_idx;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Grant vector and AND-OR operand mux; no grant leaves the operands at zero.
    always_comb begin
        grant_s = '0;
        mul_a   = '0;
        mul_b   = '0;
        if (grant_any_s) begin
            grant_s = onehot(grant_idx_s);
        end else begin
            grant_s = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            mul_a = mul_a | ({W{grant_s[i]}} & req_a[i*W +: W]);
            mul_b = mul_b | ({W{grant_s[i]}} & req_b[i*W +: W]);
        end
    end

    assign req_ready = grant_s;

    // Last-granted pointer; moves only on a completed handshake.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= IW'(NREQ - 1);
        end else if (grant_any_s) begin
            ptr_r <= grant_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Tag pipeline tracking which requester owns the product in each multiplier stage.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_r <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_idx_r[k] <= '0;
            end
        end else begin
            // Any grant is a handshake because ready is only given to a valid requester.
            tag_valid_r[0] <= grant_any_s;
            tag_idx_r[0]   <= grant_idx_s;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_valid_r[k] <= tag_valid_r[k-1];
                tag_idx_r[k]   <= tag_idx_r[k-1];
            end
        end
    end

    // Occupancy after the coming edge: new handshake plus the stages that shift along.
    always_comb begin
        inflight_next_s = CW'(grant_any_s);
        for (int k = 0; k < MUL_LAT - 1; k++) begin
            inflight_next_s = inflight_next_s + CW'(tag_valid_r[k]);
        end
    end

    // Response register: capture the product when the last tag stage is valid.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_r <= '0;
            resp_data_r  <= '0;
            inflight_r   <= '0;
        end else begin
            inflight_r <= inflight_next_s;
            if (tag_valid_r[MUL_LAT-1]) begin
                resp_valid_r <= onehot(tag_idx_r[MUL_LAT-1]);
                resp_data_r  <= mul_c;
            end else begin
                resp_valid_r <= '0;
                resp_data_r  <= resp_data_r;
            end
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign inflight   = inflight_r;

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Self-checking bench for mul_rr_arbiter with a behavioural two-stage
// multiplier attached and a queue-based reference model of the arbiter.
module tb_mul_rr_arbiter;
    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int MUL_LAT = 2;
    localparam int CW      = $clog2(MUL_LAT + 1);

    logic              CLK   = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [W-1:0]      mul_c = '0;
    logic [NREQ-1:0]   resp_valid;
    logic [W-1:0]      resp_data;
    logic [CW-1:0]     inflight;

    mul_rr_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .inflight(inflight)
    );

    always #5 CLK = ~CLK;

    // Shared multiplier: registered operands, registered low-W product.
    logic [W-1:0] op_a_r = '0;
    logic [W-1:0] op_b_r = '0;
    always @(posedge CLK) begin
        op_a_r <= mul_a;
        op_b_r <= mul_b;
        mul_c  <= op_a_r * op_b_r;
    end

    typedef struct {
        int           due;
        int           idx;
        logic [W-1:0] prod;
    } exp_t;

    typedef struct {
        int           idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] prod;
    } vec_t;

    exp_t         q[$];
    int           m_ptr;
    logic [W-1:0] m_data;
    int           edge_n;
    int           tests;
    int           fails;
    int           waits[NREQ];
    int           max_wait;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock cycle: drive at negedge, check grant/mux, then check registered outputs after the edge.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                         input logic [NREQ*W-1:0] b, output int g);
        exp_t            e;
        logic [NREQ-1:0] one;
        logic [W-1:0]    aa;
        logic [W-1:0]    bb;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        #1;
        g   = pick(v, m_ptr);
        one = '0;
        aa  = '0;
        bb  = '0;
        if (g >= 0) begin
            one[g] = 1'b1;
            aa     = a[g*W +: W];
            bb     = b[g*W +: W];
        end
        check("req_ready", W'(req_ready), W'(one));
        check("mul_a", mul_a, aa);
        check("mul_b", mul_b, bb);
        @(posedge CLK);
        #1;
        edge_n++;
        if (g >= 0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i != g && v[i]) begin
                    waits[i]++;
                    if (waits[i] > max_wait) max_wait = waits[i];
                end else begin
                    waits[i] = 0;
                end
            end
            e.due  = edge_n + MUL_LAT;
            e.idx  = g;
            e.prod = aa * bb;
            q.push_back(e);
            m_ptr = g;
        end
        one = '0;
        if (q.size() > 0 && q[0].due == edge_n) begin
            e         = q.pop_front();
            one[e.idx] = 1'b1;
            m_data    = e.prod;
        end
        check("resp_valid", W'(resp_valid), W'(one));
        check("resp_data", resp_data, m_data);
        check("inflight", W'(inflight), W'(q.size()));
        @(negedge CLK);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        q.delete();
        m_ptr  = NREQ - 1;
        m_data = '0;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        repeat (2) @(posedge CLK);
        edge_n += 2;
        #1;
        check("rst_resp_valid", W'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_inflight", W'(inflight), 32'd0);
        check("rst_req_ready", W'(req_ready), 32'd0);
        check("rst_mul_a", mul_a, 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t              tab[4];
        logic [NREQ*W-1:0] a;
        logic [NREQ*W-1:0] b;
        logic [NREQ-1:0]   rv;
        logic [NREQ-1:0]   one;
        int                g;
        int                last_g;

        tests    = 0;
        fails    = 0;
        edge_n   = 0;
        max_wait = 0;

        tab[0] = '{0, 32'd3, 32'd5, 32'd15};
        tab[1] = '{1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE};
        tab[2] = '{2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        tab[3] = '{3, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340};

        do_reset();

        // Single isolated operations with hand-computed products.
        for (int i = 0; i < 4; i++) begin
            a = '0;
            b = '0;
            a[tab[i].idx*W +: W] = tab[i].a;
            b[tab[i].idx*W +: W] = tab[i].b;
            rv = '0;
            rv[tab[i].idx] = 1'b1;
            cycle(rv, a, b, g);
            check("tab_grant", W'(g), W'(tab[i].idx));
            check("tab_inflight_e1", W'(inflight), 32'd1);
            cycle('0, a, b, g);
            check("tab_inflight_e2", W'(inflight), 32'd1);
            check("tab_no_resp_yet", W'(resp_valid), 32'd0);
            cycle('0, a, b, g);
            one = '0;
            one[tab[i].idx] = 1'b1;
            check("tab_resp_valid", W'(resp_valid), W'(one));
            check("tab_resp_data", resp_data, tab[i].prod);
            check("tab_inflight_e3", W'(inflight), 32'd0);
            cycle('0, a, b, g);
            check("tab_resp_once", W'(resp_valid), 32'd0);
        end

        // All four valid for eight cycles: strict rotation starting at 0.
        for (int i = 0; i < NREQ; i++) begin
            a[i*W +: W] = 32'd100 + 32'(i);
            b[i*W +: W] = 32'd7 + 32'(i);
        end
        for (int n = 0; n < 8; n++) begin
            cycle(4'hF, a, b, g);
            check("rr_order", W'(g), W'(n % NREQ));
        end
        repeat (3) cycle('0, a, b, g);

        // Only requester 2 with last grant 3, then requester 3 alone.
        cycle(4'b0100, a, b, g);
        check("only2_grant", W'(req_ready), 32'd4);
        check("only2_idx", W'(g), 32'd2);
        cycle(4'b1000, a, b, g);
        check("then3_idx", W'(g), 32'd3);

        // Reset with two operations in flight: dropped, no responses.
        cycle(4'b0001, a, b, g);
        cycle(4'b0010, a, b, g);
        check("pre_rst_inflight", W'(inflight), 32'd2);
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check("rst_now_inflight", W'(inflight), 32'd0);
        check("rst_now_resp_valid", W'(resp_valid), 32'd0);
        do_reset();
        cycle(4'hF, a, b, g);
        check("post_rst_first", W'(g), 32'd0);
        repeat (4) cycle('0, a, b, g);

        // Randomized traffic; pending requesters hold their operands until served.
        rv     = '0;
        last_g = -1;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        max_wait = 0;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i] || last_g == i) begin
                    rv[i] = ($urandom_range(0, 3) != 0);
                    a[i*W +: W] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom();
                    b[i*W +: W] = $urandom();
                end
            end
            cycle(rv, a, b, g);
            last_g = g;
        end
        repeat (4) cycle('0, a, b, g);
        check("no_starvation", W'(max_wait <= NREQ - 1), 32'd1);
        check("queue_drained", W'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
